// File: rtl/mem_arbiter_pkg.sv
// Shared types for the fetch/load-store memory arbiter: FSM states, burst
// size codes, grant encoding and the burst-length decode.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_XFER  = 2'd2,
    ST_ERR   = 2'd3
  } state_t;

  localparam logic [1:0] ACC_1  = 2'b00;
  localparam logic [1:0] ACC_4  = 2'b01;
  localparam logic [1:0] ACC_8  = 2'b10;
  localparam logic [1:0] ACC_16 = 2'b11;

  typedef enum logic {
    GRANT_I = 1'b0,
    GRANT_D = 1'b1
  } grant_t;

  function automatic logic [4:0] burst_len(input logic [1:0] code);
    case (code)
      ACC_1:   return 5'd1;
      ACC_4:   return 5'd4;
      ACC_8:   return 5'd8;
      default: return 5'd16;
    endcase
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_arbiter2.sv
// Two-requester round-robin arbiter; the port that did not win last time
// takes a tie, and the history only moves when a grant is accepted.
module rr_arbiter2
  import mem_arb_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic req_fetch,
  input  logic req_data,
  input  logic enable,
  output logic grant_fetch,
  output logic grant_data
);

  grant_t last_grant;

  always_comb begin
    grant_fetch = req_fetch && (!req_data || last_grant == GRANT_D);
    grant_data  = req_data  && (!req_fetch || last_grant == GRANT_I);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= GRANT_D;
    end else if (enable && grant_fetch) begin
      last_grant <= GRANT_I;
    end else if (enable && grant_data) begin
      last_grant <= GRANT_D;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares main memory between the instruction-fetch and load/store ports:
// arbitration, enable/burst sequencing, beat steering and misalignment rejects.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDRESS_SIZE = 32,
  parameter int DATA_SIZE    = 32,
  parameter int ACCESS_SIZE  = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_req,
  input  logic [ADDRESS_SIZE-1:0] i_addr,
  input  logic [ACCESS_SIZE-1:0]  i_acc_size,
  output logic                    i_ack,
  output logic                    i_done,
  output logic                    i_err,
  output logic [DATA_SIZE-1:0]    i_rdata,
  input  logic                    d_req,
  input  logic                    d_wren,
  input  logic [ADDRESS_SIZE-1:0] d_addr,
  input  logic [DATA_SIZE-1:0]    d_wdata,
  output logic                    d_ack,
  output logic                    d_err,
  output logic [DATA_SIZE-1:0]    d_rdata,
  output logic                    mem_enable,
  output logic                    mem_wren,
  output logic [ADDRESS_SIZE-1:0] mem_addr,
  output logic [ACCESS_SIZE-1:0]  mem_acc_size,
  output logic [DATA_SIZE-1:0]    mem_d_in,
  input  logic [DATA_SIZE-1:0]    mem_d_out,
  input  logic                    mem_busy
);

  state_t                  state;
  logic                    cmd_is_data;
  logic [3:0]              beat;
  logic [3:0]              next_beat;
  logic [3:0]              last_beat;
  logic                    grant_fetch;
  logic                    grant_data;
  logic [ADDRESS_SIZE-1:0] sel_addr;
  logic                    unused_busy;

  // The memory paces beats one per cycle, so its busy flag carries no extra information.
  assign unused_busy = mem_busy;
  assign sel_addr    = grant_data ? d_addr : i_addr;
  assign last_beat   = 4'(burst_len(mem_acc_size) - 5'd1);
  assign next_beat   = (state == ST_ISSUE) ? 4'd0 : beat + 4'd1;

  rr_arbiter2 u_rr (
    .clk         (clk),
    .rst         (rst),
    .req_fetch   (i_req),
    .req_data    (d_req),
    .enable      (state == ST_IDLE),
    .grant_fetch (grant_fetch),
    .grant_data  (grant_data)
  );

  // Responses are registered one edge ahead, so a beat sampled at the end of
  // ISSUE/XFER becomes visible as an ack during the following XFER cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      cmd_is_data  <= 1'b0;
      beat         <= 4'd0;
      mem_enable   <= 1'b0;
      mem_wren     <= 1'b0;
      mem_addr     <= '0;
      mem_acc_size <= '0;
      mem_d_in     <= '0;
      i_ack        <= 1'b0;
      i_done       <= 1'b0;
      i_err        <= 1'b0;
      i_rdata      <= '0;
      d_ack        <= 1'b0;
      d_err        <= 1'b0;
      d_rdata      <= '0;
    end else begin
      i_ack  <= 1'b0;
      i_done <= 1'b0;
      i_err  <= 1'b0;
      d_ack  <= 1'b0;
      d_err  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (grant_fetch || grant_data) begin
            cmd_is_data <= grant_data;
            if (sel_addr[1:0] != 2'b00) begin
              state <= ST_ERR;
              if (grant_data) begin
                d_ack   <= 1'b1;
                d_err   <= 1'b1;
                d_rdata <= '0;
              end else begin
                i_ack   <= 1'b1;
                i_done  <= 1'b1;
                i_err   <= 1'b1;
                i_rdata <= '0;
              end
            end else begin
              state        <= ST_ISSUE;
              mem_enable   <= 1'b1;
              mem_wren     <= grant_data & d_wren;
              mem_addr     <= sel_addr;
              mem_acc_size <= grant_data ? ACCESS_SIZE'(ACC_1) : i_acc_size;
              mem_d_in     <= (grant_data & d_wren) ? d_wdata : '0;
            end
          end
        end
        ST_ISSUE, ST_XFER: begin
          if (state == ST_XFER && beat == last_beat) begin
            state      <= ST_IDLE;
            mem_enable <= 1'b0;
            mem_wren   <= 1'b0;
          end else begin
            state <= ST_XFER;
            beat  <= next_beat;
            if (cmd_is_data) begin
              d_ack   <= 1'b1;
              d_rdata <= mem_wren ? '0 : mem_d_out;
            end else begin
              i_ack   <= 1'b1;
              i_done  <= (next_beat == last_beat);
              i_rdata <= mem_d_out;
            end
          end
        end
        ST_ERR: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a word-array memory fixture plus a transaction-level
// model that predicts every cycle's handshakes from grant order and burst lengths.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req;
  logic [31:0] i_addr;
  logic [1:0]  i_acc_size;
  logic        i_ack;
  logic        i_done;
  logic        i_err;
  logic [31:0] i_rdata;
  logic        d_req;
  logic        d_wren;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_ack;
  logic        d_err;
  logic [31:0] d_rdata;
  logic        mem_enable;
  logic        mem_wren;
  logic [31:0] mem_addr;
  logic [1:0]  mem_acc_size;
  logic [31:0] mem_d_in;
  logic [31:0] mem_d_out;
  logic        mem_busy;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk          (clk),
    .rst          (rst),
    .i_req        (i_req),
    .i_addr       (i_addr),
    .i_acc_size   (i_acc_size),
    .i_ack        (i_ack),
    .i_done       (i_done),
    .i_err        (i_err),
    .i_rdata      (i_rdata),
    .d_req        (d_req),
    .d_wren       (d_wren),
    .d_addr       (d_addr),
    .d_wdata      (d_wdata),
    .d_ack        (d_ack),
    .d_err        (d_err),
    .d_rdata      (d_rdata),
    .mem_enable   (mem_enable),
    .mem_wren     (mem_wren),
    .mem_addr     (mem_addr),
    .mem_acc_size (mem_acc_size),
    .mem_d_in     (mem_d_in),
    .mem_d_out    (mem_d_out),
    .mem_busy     (mem_busy)
  );

  function automatic logic [31:0] init_word(input logic [7:0] i);
    return {i, 8'hC3, ~i, 8'h5A} ^ 32'h0F1E_2D3C;
  endfunction

  // Memory fixture: 256 words, beat k of a burst is presented while mem_enable
  // has been high for k edges; stores land on the first enabled edge.
  logic [31:0] mem_store [256];
  bit          written   [256];
  logic [7:0]  k = 8'd0;
  logic [7:0]  mem_idx;

  assign mem_idx   = mem_addr[9:2] + k;
  assign mem_d_out = written[mem_idx] ? mem_store[mem_idx] : init_word(mem_idx);
  assign mem_busy  = mem_enable && (k != 8'd0);

  always @(posedge clk) begin
    if (mem_enable) begin
      if (mem_wren && k == 8'd0) begin
        mem_store[mem_addr[9:2]] <= mem_d_in;
        written[mem_addr[9:2]]   <= 1'b1;
      end
      k <= k + 8'd1;
    end else begin
      k <= 8'd0;
    end
  end

  logic [5:0] ctrl_obs;
  assign ctrl_obs = {mem_enable, i_ack, i_done, i_err, d_ack, d_err};

  // Reference model state and per-cycle expectations for one episode.
  logic [31:0] ref_mem [256];
  bit          last_d;
  logic [5:0]  e_ctrl   [64];
  logic [31:0] e_irdata [64];
  logic [31:0] e_drdata [64];
  logic [34:0] e_cmd    [64];
  logic [31:0] e_din    [64];
  bit          e_wr     [64];
  bit          e_drop_i [64];
  bit          e_drop_d [64];

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic schedule(input bit is_data, input logic [31:0] addr, input logic [1:0] size,
                          input bit wren, input logic [31:0] wdata, inout int s);
    int n;
    int c;
    logic [7:0] idx;
    idx = addr[9:2];
    if (addr[1:0] != 2'b00) begin
      e_ctrl[s+1] = is_data ? 6'b000011 : 6'b011100;
      if (is_data) begin
        e_drdata[s+1] = 32'h0;
        e_drop_d[s+1] = 1'b1;
      end else begin
        e_irdata[s+1] = 32'h0;
        e_drop_i[s+1] = 1'b1;
      end
      s += 2;
    end else begin
      n = (is_data || size == 2'b00) ? 1 : (2 << size);
      for (int cc = s + 1; cc <= s + n + 1; cc++) begin
        e_ctrl[cc][5] = 1'b1;
        e_cmd[cc]     = {wren, (is_data ? 2'b00 : size), addr};
        e_din[cc]     = wdata;
        e_wr[cc]      = wren;
      end
      for (int b = 0; b < n; b++) begin
        c = s + 2 + b;
        if (is_data) begin
          e_ctrl[c][1] = 1'b1;
          e_drdata[c]  = wren ? 32'h0 : ref_mem[idx];
          e_drop_d[c]  = 1'b1;
        end else begin
          e_ctrl[c][4] = 1'b1;
          e_ctrl[c][3] = (b == n - 1);
          e_irdata[c]  = ref_mem[8'(int'(idx) + b)];
        end
      end
      if (!is_data) e_drop_i[s+n+1] = 1'b1;
      if (is_data && wren) ref_mem[idx] = wdata;
      s += n + 2;
    end
  endtask

  // Called at a negedge while the DUT is idle; leaves it idle at a negedge.
  task automatic applyStimulus(input bit f_en, input logic [31:0] f_addr, input logic [1:0] f_size,
                               input bit f_early, input bit d_en, input bit d_wr,
                               input logic [31:0] d_a, input logic [31:0] d_wd);
    int s;
    int last_cyc;
    bit first_data;
    s = 0;
    for (int i = 0; i < 64; i++) begin
      e_ctrl[i]   = 6'b0;
      e_irdata[i] = 32'h0;
      e_drdata[i] = 32'h0;
      e_cmd[i]    = 35'h0;
      e_din[i]    = 32'h0;
      e_wr[i]     = 1'b0;
      e_drop_i[i] = 1'b0;
      e_drop_d[i] = 1'b0;
    end
    first_data = (f_en && d_en) ? !last_d : d_en;
    if (f_en || d_en) begin
      if (first_data) schedule(1'b1, d_a, 2'b00, d_wr, d_wd, s);
      else            schedule(1'b0, f_addr, f_size, 1'b0, 32'h0, s);
      if (!first_data && f_early && f_addr[1:0] == 2'b00 && f_size != 2'b00) e_drop_i[1] = 1'b1;
      last_d = first_data;
      if (f_en && d_en) begin
        if (first_data) schedule(1'b0, f_addr, f_size, 1'b0, 32'h0, s);
        else            schedule(1'b1, d_a, 2'b00, d_wr, d_wd, s);
        last_d = !first_data;
      end
    end
    last_cyc   = (s < 2) ? 2 : s;
    i_req      = f_en;
    i_addr     = f_addr;
    i_acc_size = f_size;
    d_req      = d_en;
    d_wren     = d_wr;
    d_addr     = d_a;
    d_wdata    = d_wd;
    for (int c = 1; c <= last_cyc; c++) begin
      @(posedge clk);
      @(negedge clk);
      checkOutput($sformatf("ctrl@%0d", c), ctrl_obs, e_ctrl[c]);
      if (e_ctrl[c][4]) checkOutput($sformatf("i_rdata@%0d", c), i_rdata, e_irdata[c]);
      if (e_ctrl[c][1]) checkOutput($sformatf("d_rdata@%0d", c), d_rdata, e_drdata[c]);
      if (e_ctrl[c][5]) checkOutput($sformatf("cmd@%0d", c), {mem_wren, mem_acc_size, mem_addr}, e_cmd[c]);
      if (e_ctrl[c][5] && e_wr[c]) checkOutput($sformatf("mem_d_in@%0d", c), mem_d_in, e_din[c]);
      if (e_drop_i[c]) i_req = 1'b0;
      if (e_drop_d[c]) d_req = 1'b0;
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] fa;
    logic [31:0] da;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(8'(i));
    last_d     = 1'b1;
    rst        = 1'b1;
    i_req      = 1'b0;
    i_addr     = 32'h0;
    i_acc_size = 2'b00;
    d_req      = 1'b0;
    d_wren     = 1'b0;
    d_addr     = 32'h0;
    d_wdata    = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_ctrl", ctrl_obs, 6'b0);
    checkOutput("reset_rdata", {i_rdata, d_rdata}, 64'h0);
    checkOutput("reset_cmd", {mem_wren, mem_acc_size, mem_addr}, 35'h0);
    checkOutput("reset_din", mem_d_in, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // Ties straight out of reset: fetch first, then alternating.
    applyStimulus(1'b1, 32'h8002_0100, 2'b00, 1'b0, 1'b1, 1'b0, 32'h8002_0200, 32'h0);
    applyStimulus(1'b1, 32'h8002_0104, 2'b01, 1'b0, 1'b1, 1'b0, 32'h8002_0204, 32'h0);

    applyStimulus(1'b1, 32'h8002_0000, 2'b01, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    applyStimulus(1'b0, 32'h0, 2'b00, 1'b0, 1'b1, 1'b1, 32'h8002_0010, 32'hDEAD_BEEF);
    applyStimulus(1'b0, 32'h0, 2'b00, 1'b0, 1'b1, 1'b0, 32'h8002_0010, 32'h0);
    checkOutput("load_deadbeef", d_rdata, 32'hDEAD_BEEF);
    applyStimulus(1'b0, 32'h0, 2'b00, 1'b0, 1'b1, 1'b0, 32'h8002_0002, 32'h0);
    applyStimulus(1'b1, 32'h8002_0080, 2'b10, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    applyStimulus(1'b1, 32'h8002_0031, 2'b11, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);

    for (int e = 0; e < 150; e++) begin
      fa = 32'h8002_0000 | (32'($urandom_range(0, 255)) << 2);
      if ($urandom_range(0, 7) == 0) fa[1:0] = 2'($urandom_range(1, 3));
      da = 32'h8002_0000 | (32'($urandom_range(0, 255)) << 2);
      if ($urandom_range(0, 7) == 0) da[1:0] = 2'($urandom_range(1, 3));
      applyStimulus($urandom_range(0, 3) != 0, fa, 2'($urandom_range(0, 3)), $urandom_range(0, 3) == 0,
                    $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), da, $urandom);
    end

    // Reset while a 16-word fetch is on its third beat.
    i_req      = 1'b1;
    i_addr     = 32'h8002_0040;
    i_acc_size = 2'b11;
    repeat (4) begin
      @(posedge clk);
      @(negedge clk);
    end
    checkOutput("beat2_ack", {i_ack, i_done}, 2'b10);
    checkOutput("beat2_data", i_rdata, ref_mem[8'h12]);
    rst   = 1'b1;
    i_req = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("midrst_ctrl", ctrl_obs, 6'b0);
    checkOutput("midrst_rdata", {i_rdata, d_rdata}, 64'h0);
    checkOutput("midrst_cmd", {mem_wren, mem_acc_size, mem_addr}, 35'h0);
    rst    = 1'b0;
    last_d = 1'b1;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      checkOutput("post_rst_quiet", ctrl_obs, 6'b0);
    end
    applyStimulus(1'b1, 32'h8002_0300, 2'b00, 1'b0, 1'b1, 1'b0, 32'h8002_0304, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port controller that shares the single main memory between the instruction-fetch port (read-only, burst-capable) and the load/store port (single-word read/write). It serialises requests, sequences the memory's enable/burst protocol, steers read beats back to the winning requester, and rejects misaligned accesses without touching memory. It sits between the fetch and memory stages and the main memory.

## Interface
- ADDRESS_SIZE, 32, address width
- DATA_SIZE, 32, data word width
- ACCESS_SIZE, 2, burst-size code width

- clk  in  1  system clock, all logic on posedge
- rst  in  1  synchronous, active-high reset
- i_req  in  1  fetch request; held until i_done
- i_addr  in  ADDRESS_SIZE  fetch start byte address
- i_acc_size  in  ACCESS_SIZE  burst code: 00=1, 01=4, 10=8, 11=16 words
- i_ack  out  1  one fetched word valid on i_rdata
- i_done  out  1  last ack of the fetch transaction
- i_err  out  1  misaligned fetch, valid with i_ack/i_done
- i_rdata  out  DATA_SIZE  fetched word
- d_req  in  1  load/store request; held until d_ack
- d_wren  in  1  1=store, 0=load
- d_addr  in  ADDRESS_SIZE  word byte address
- d_wdata  in  DATA_SIZE  store data
- d_ack  out  1  transaction complete (single cycle)
- d_err  out  1  misaligned access, valid with d_ack
- d_rdata  out  DATA_SIZE  load data, valid with d_ack
- mem_enable  out  1  memory enable, held for whole transaction
- mem_wren  out  1  memory write enable
- mem_addr  out  ADDRESS_SIZE  memory start address
- mem_acc_size  out  ACCESS_SIZE  memory burst code
- mem_d_in  out  DATA_SIZE  memory write data
- mem_d_out  in  DATA_SIZE  memory read data, one word per cycle after issue
- mem_busy  in  1  memory burst in progress (monitor only)

## Operation
- FSM: IDLE, ISSUE, XFER, ERR.
- IDLE: if any req, arbitrate, latch winner's addr/size/wren/wdata into command registers. addr[1:0]!=0 -> ERR; else -> ISSUE.
- Arbitration: single requester wins; both pending -> round-robin via last_grant, reset value last_grant=D (fetch wins first tie). last_grant updated on every grant, including error grants.
- ISSUE: mem_enable=1, command outputs driven from latched registers; beat counter=0; -> XFER.
- XFER: mem_enable and command held stable. Each cycle: read -> route mem_d_out to winner's rdata, pulse ack, counter+1; at counter==N-1 assert done (fetch) / ack (data), -> IDLE. Store: N=1, one XFER cycle, d_ack with d_rdata=0.
- Data port always issues acc_size=00; N computed from latched size code (1/4/8/16), counter 4 bits.
- ERR: one cycle, winner's ack (+done for fetch) with err=1, rdata=0, no mem_enable; -> IDLE.
- Request deassertion mid-transaction ignored; transaction completes with all beats acked.
- Non-granted port receives no ack; its request stays pending.

## Timing
- Reset: state=IDLE, mem_enable=0, mem_wren=0, mem_addr=0, mem_acc_size=0, mem_d_in=0, all acks/done/err=0, rdata=0, counter=0, last_grant=D.
- rst mid-transaction: next cycle as reset; in-flight transaction dropped, no ack; memory write already issued is not undone.
- Request sampled in IDLE at edge t; ISSUE during t+1; first ack in cycle t+2; N-word fetch occupies IDLE+ISSUE+N cycles; next grant decided in the IDLE cycle after last ack (no back-to-back without IDLE).
- Error response: ack in cycle t+1.
- All outputs registered except none; acks are exactly one cycle per beat.

## Structure
- Package mem_arb_pkg: state enum, acc_size codes, burst-length function (code -> word count), last_grant encoding.
- Sub-module rr_arbiter2: two-request round-robin with last_grant register, grant enable input.
- Remainder (FSM, command registers, beat counter, response steering) in mem_arbiter.

## Test plan
- Reset then fetch only: i_addr=32'h80020000, size=01 -> mem_enable high 5 cycles, 4 i_ack in cycles t+2..t+5, i_done with 4th, data = words at 0x80020000..0C.
- Store then load: d_wren=1, d_addr=32'h80020010, d_wdata=32'hDEADBEEF -> d_ack at t+2; load same addr -> d_rdata=32'hDEADBEEF.
- Simultaneous i_req/d_req from reset -> fetch granted first, then data; repeat -> alternation I,D,I,D.
- Misaligned d_addr=32'h80020002 -> d_ack+d_err at t+1, d_rdata=0, mem_enable never asserted.
- rst asserted during beat 2 of 16-word fetch -> next cycle all outputs at reset values, no further i_ack.
- i_req dropped after ISSUE of size=10 fetch -> all 8 acks still delivered, then IDLE.
